// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset core (IF, ID, EX, MEM, WB) with internal unified
// 1024x32 memory and 32x32 register file; runs from word 0 until HLT retires.
module pipe_mips32 (
  input  logic       clk,
  input  logic       rst_n,
  output logic       halted,
  output logic [9:0] pc
);
  localparam int DATA_W = 32;

  localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h02, OP_OR   = 6'h03;
  localparam logic [5:0] OP_SLT  = 6'h04, OP_MUL  = 6'h05, OP_LW   = 6'h08, OP_SW   = 6'h09;
  localparam logic [5:0] OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI = 6'h0C, OP_BNEZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ = 6'h0E, OP_HLT  = 6'h3F;

  logic [DATA_W-1:0] Mem [0:1023];
  logic [DATA_W-1:0] Reg [0:31];
  logic [9:0]        PC;
  logic              HALTED, TAKEN_BRANCH, stop;

  logic [31:0]              ir_p0, ir_p1;
  logic [9:0]               npc_p0, npc_p1;
  logic signed [DATA_W-1:0] a_p1, b_p1, alu_p2, sd_p2, res_p3;
  logic [4:0]               dst_p2, dst_p3;
  logic                     wr_p2, ld_p2, st_p2, hlt_p2, wr_p3, hlt_p3;
  logic                     vld_p0, vld_p1, vld_p2, vld_p3;

  function automatic logic signed [DATA_W-1:0] sext(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

  function automatic logic writes_reg(input logic [5:0] op);
    return (op <= OP_MUL) || (op == OP_LW) || (op >= OP_ADDI && op <= OP_SLTI);
  endfunction

  function automatic logic signed [DATA_W-1:0] alu(input logic [5:0] op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b,
                                                   input logic signed [DATA_W-1:0] imm);
    case (op)
      OP_ADD:       return a + b;
      OP_SUB:       return a - b;
      OP_AND:       return a & b;
      OP_OR:        return a | b;
      OP_SLT:       return (a < b) ? 32'sd1 : 32'sd0;
      OP_MUL:       return a * b;
      OP_ADDI:      return a + imm;
      OP_SUBI:      return a - imm;
      OP_SLTI:      return (a < imm) ? 32'sd1 : 32'sd0;
      OP_LW, OP_SW: return a + imm;
      default:      return '0;
    endcase
  endfunction

  // ID: register read with write-before-read bypass from WB
  logic                     wb_en, hlt_id;
  logic [4:0]               rs_id, rt_id;
  logic signed [DATA_W-1:0] rs_val, rt_val;

  assign wb_en  = rst_n && vld_p3 && wr_p3 && !HALTED;
  assign hlt_id = vld_p0 && (ir_p0[31:26] == OP_HLT);
  assign rs_id  = ir_p0[25:21];
  assign rt_id  = ir_p0[20:16];

  always_comb begin
    rs_val = Reg[rs_id];
    rt_val = Reg[rt_id];
    if (wb_en && dst_p3 == rs_id) rs_val = res_p3;
    if (wb_en && dst_p3 == rt_id) rt_val = res_p3;
    if (rs_id == 5'd0) rs_val = '0;
    if (rt_id == 5'd0) rt_val = '0;
  end

  // EX: operand forwarding (EX/MEM beats MEM/WB), ALU and branch resolution
  logic [5:0]               op_ex;
  logic [4:0]               rs_ex, rt_ex, dst_ex;
  logic signed [DATA_W-1:0] imm_ex, fa, fb, alu_ex;
  logic                     taken;
  logic [9:0]               target;

  assign op_ex  = ir_p1[31:26];
  assign rs_ex  = ir_p1[25:21];
  assign rt_ex  = ir_p1[20:16];
  assign imm_ex = sext(ir_p1[15:0]);
  assign dst_ex = (op_ex <= OP_MUL) ? ir_p1[15:11] : rt_ex;

  always_comb begin
    fa = a_p1;
    fb = b_p1;
    if (vld_p3 && wr_p3 && dst_p3 == rs_ex) fa = res_p3;
    if (vld_p3 && wr_p3 && dst_p3 == rt_ex) fb = res_p3;
    // A load still in EX/MEM only holds its address, so it is not a forwarding source.
    if (vld_p2 && wr_p2 && !ld_p2 && dst_p2 == rs_ex) fa = alu_p2;
    if (vld_p2 && wr_p2 && !ld_p2 && dst_p2 == rt_ex) fb = alu_p2;
  end

  assign alu_ex = alu(op_ex, fa, fb, imm_ex);
  assign taken  = vld_p1 && (((op_ex == OP_BNEZ) && (fa != '0)) ||
                             ((op_ex == OP_BEQZ) && (fa == '0)));
  assign target = npc_p1 + imm_ex[9:0];

  // Control: PC, valids, halt state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      stop         <= 1'b0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      vld_p3       <= 1'b0;
    end else begin
      TAKEN_BRANCH <= taken;
      if (taken) begin
        PC     <= target;
        vld_p0 <= 1'b0;
      end else if (stop || hlt_id) begin
        vld_p0 <= 1'b0;
      end else begin
        PC     <= PC + 10'd1;
        vld_p0 <= 1'b1;
      end
      // An HLT sitting in a taken branch's shadow is squashed and must not stop fetch.
      if (hlt_id && !taken) stop <= 1'b1;
      vld_p1 <= vld_p0 && !taken;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (vld_p3 && hlt_p3) HALTED <= 1'b1;
    end
  end

  // Datapath stage registers, memory and register-file writes
  always_ff @(posedge clk) begin
    ir_p0  <= Mem[PC];
    npc_p0 <= PC + 10'd1;
    ir_p1  <= ir_p0;
    npc_p1 <= npc_p0;
    a_p1   <= rs_val;
    b_p1   <= rt_val;
    dst_p2 <= dst_ex;
    wr_p2  <= writes_reg(op_ex) && (dst_ex != 5'd0);
    ld_p2  <= (op_ex == OP_LW);
    st_p2  <= (op_ex == OP_SW);
    hlt_p2 <= (op_ex == OP_HLT);
    alu_p2 <= alu_ex;
    sd_p2  <= fb;
    dst_p3 <= dst_p2;
    wr_p3  <= wr_p2;
    hlt_p3 <= hlt_p2;
    res_p3 <= ld_p2 ? Mem[alu_p2[9:0]] : alu_p2;
    if (rst_n && vld_p2 && st_p2 && !HALTED) Mem[alu_p2[9:0]] <= sd_p2;
    if (wb_en) Reg[dst_p3] <= res_p3;
  end

  assign halted = HALTED;
  assign pc     = PC;
endmodule

// File: tb/tb_pipe_mips32.sv
// Scoreboard bench for pipe_mips32: programs are preloaded hierarchically and final
// register/memory state is compared against expectations queued at load time.
module tb_pipe_mips32;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halted;
  logic [9:0] pc;
  int total = 0;
  int bad = 0;

  typedef struct { int kind; int idx; logic [31:0] val; } exp_t;
  exp_t sb[$];

  localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, AND_ = 6'h02, OR_ = 6'h03, SLT = 6'h04;
  localparam logic [5:0] MUL = 6'h05, LW = 6'h08, SW = 6'h09, ADDI = 6'h0A, SUBI = 6'h0B;
  localparam logic [5:0] SLTI = 6'h0C, BNEZ = 6'h0D, BEQZ = 6'h0E, HLT = 6'h3F;

  pipe_mips32 dut (.clk(clk), .rst_n(rst_n), .halted(halted), .pc(pc));

  always #5 clk = ~clk;

  function automatic logic [31:0] encr(logic [5:0] op, int rs, int rt, int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enci(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] peek(exp_t e);
    return (e.kind == 0) ? dut.Reg[e.idx] : dut.Mem[e.idx];
  endfunction

  task automatic put(int kind, int idx, logic [31:0] val);
    exp_t e;
    e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic clear_state();
    for (int i = 0; i < 1024; i++) dut.Mem[i] <= 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] <= k;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int max, output int cyc, output int nbr);
    cyc = -1;
    nbr = 0;
    for (int c = 1; c <= max; c++) begin
      @(posedge clk);
      #1;
      if (dut.TAKEN_BRANCH) nbr++;
      if (halted) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (pc !== 10'd0) begin bad++; $display("FAIL reset_pc got %0d want 0", pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got %b want 0", halted); end
    total++; if (dut.TAKEN_BRANCH !== 1'b0) begin bad++; $display("FAIL reset_taken got %b want 0", dut.TAKEN_BRANCH); end
  endtask

  task automatic test_reference();
    int cyc, nbr;
    exp_t e;
    logic [31:0] act;
    logic [31:0] prog [8] = '{32'h28010078, 32'h0C631800, 32'h20220000, 32'h0C631800,
                              32'h2842002D, 32'h0C631800, 32'h24220001, 32'hFC000000};
    rst_n = 1'b0;
    @(posedge clk);
    clear_state();
    dut.Mem[120] <= 32'd85;
    for (int i = 0; i < 8; i++) dut.Mem[i] <= prog[i];
    put(0, 1, 120); put(0, 2, 130); put(0, 3, 3); put(1, 120, 85); put(1, 121, 130);
    release_reset();
    run_to_halt(100, cyc, nbr);
    total++; if (cyc !== 12) begin bad++; $display("FAIL ref_halt_cycle got %0d want 12", cyc); end
    total++; if (pc !== 10'd8) begin bad++; $display("FAIL ref_pc got %0d want 8", pc); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); act = peek(e); total++;
      if (act !== e.val) begin bad++; $display("FAIL ref_%s[%0d] got %h want %h", (e.kind == 0) ? "reg" : "mem", e.idx, act, e.val); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nbr;
    exp_t e;
    logic [31:0] act;
    logic [31:0] prog [10] = '{enci(ADDI, 0, 1, 10), encr(ADD, 1, 1, 2), encr(SUB, 2, 1, 3),
                               enci(SUBI, 0, 6, 3), encr(SLT, 6, 1, 7), encr(MUL, 6, 1, 8),
                               enci(SLTI, 6, 9, -2), encr(AND_, 2, 3, 10), encr(OR_, 2, 3, 11),
                               enci(HLT, 0, 0, 0)};
    rst_n = 1'b0;
    @(posedge clk);
    clear_state();
    for (int i = 0; i < 10; i++) dut.Mem[i] <= prog[i];
    put(0, 1, 10); put(0, 2, 20); put(0, 3, 10); put(0, 6, 32'hFFFFFFFD); put(0, 7, 1);
    put(0, 8, 32'hFFFFFFE2); put(0, 9, 1); put(0, 10, 0); put(0, 11, 30);
    release_reset();
    run_to_halt(100, cyc, nbr);
    total++; if (cyc !== 14) begin bad++; $display("FAIL b2b_halt_cycle got %0d want 14", cyc); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); act = peek(e); total++;
      if (act !== e.val) begin bad++; $display("FAIL b2b_%s[%0d] got %h want %h", (e.kind == 0) ? "reg" : "mem", e.idx, act, e.val); end
    end
  endtask

  task automatic test_loop();
    int cyc, nbr;
    exp_t e;
    logic [31:0] act;
    logic [31:0] prog [6] = '{enci(ADDI, 0, 1, 3), enci(SUBI, 1, 1, 1), enci(ADDI, 4, 4, 2),
                              enci(BNEZ, 1, 0, -3), enci(HLT, 0, 0, 0), enci(SW, 0, 4, 200)};
    rst_n = 1'b0;
    @(posedge clk);
    clear_state();
    for (int i = 0; i < 6; i++) dut.Mem[i] <= prog[i];
    dut.Reg[4] <= 32'd0;
    dut.Mem[200] <= 32'hDEAD;
    put(0, 1, 0); put(0, 4, 6); put(1, 200, 32'hDEAD);
    release_reset();
    run_to_halt(100, cyc, nbr);
    total++; if (cyc !== 19) begin bad++; $display("FAIL loop_halt_cycle got %0d want 19", cyc); end
    total++; if (nbr !== 2) begin bad++; $display("FAIL loop_taken_count got %0d want 2", nbr); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); act = peek(e); total++;
      if (act !== e.val) begin bad++; $display("FAIL loop_%s[%0d] got %h want %h", (e.kind == 0) ? "reg" : "mem", e.idx, act, e.val); end
    end
  endtask

  task automatic test_r0_unknown();
    int cyc, nbr;
    exp_t e;
    logic [31:0] act;
    logic [31:0] prog [7] = '{enci(ADDI, 0, 0, 5), enci(6'h20, 1, 2, 100), encr(ADD, 0, 0, 5),
                              enci(BEQZ, 0, 0, 2), enci(ADDI, 0, 12, 1), enci(ADDI, 0, 13, 1),
                              enci(HLT, 0, 0, 0)};
    rst_n = 1'b0;
    @(posedge clk);
    clear_state();
    for (int i = 0; i < 7; i++) dut.Mem[i] <= prog[i];
    dut.Mem[101] <= 32'h5A5A;
    put(0, 0, 0); put(0, 5, 0); put(0, 2, 2); put(0, 12, 12); put(0, 13, 13); put(1, 101, 32'h5A5A);
    release_reset();
    run_to_halt(100, cyc, nbr);
    total++; if (cyc !== 11) begin bad++; $display("FAIL r0_halt_cycle got %0d want 11", cyc); end
    total++; if (nbr !== 1) begin bad++; $display("FAIL r0_taken_count got %0d want 1", nbr); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); act = peek(e); total++;
      if (act !== e.val) begin bad++; $display("FAIL r0_%s[%0d] got %h want %h", (e.kind == 0) ? "reg" : "mem", e.idx, act, e.val); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, nbr;
    exp_t e;
    logic [31:0] act;
    logic [31:0] prog [4] = '{enci(ADDI, 0, 1, 7), encr(OR_, 3, 3, 3), enci(SW, 0, 1, 50),
                              enci(HLT, 0, 0, 0)};
    rst_n = 1'b0;
    @(posedge clk);
    clear_state();
    for (int i = 0; i < 4; i++) dut.Mem[i] <= prog[i];
    dut.Mem[50] <= 32'h1111;
    release_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (pc !== 10'd0) begin bad++; $display("FAIL mid_reset_pc got %0d want 0", pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL mid_reset_halted got %b want 0", halted); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dut.Mem[50] !== 32'h1111) begin bad++; $display("FAIL mid_aborted_store got %h want 00001111", dut.Mem[50]); end
    put(0, 1, 7); put(1, 50, 7);
    run_to_halt(100, cyc, nbr);
    total++; if (cyc !== 5) begin bad++; $display("FAIL mid_restart_halt got %0d want 5", cyc); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); act = peek(e); total++;
      if (act !== e.val) begin bad++; $display("FAIL mid_%s[%0d] got %h want %h", (e.kind == 0) ? "reg" : "mem", e.idx, act, e.val); end
    end
  endtask

  task automatic test_halt_fence();
    int cyc, nbr;
    exp_t e;
    logic [31:0] act;
    logic [31:0] prog [4] = '{enci(ADDI, 0, 1, 9), enci(HLT, 0, 0, 0), enci(SW, 0, 1, 60),
                              enci(ADDI, 0, 2, 1)};
    rst_n = 1'b0;
    @(posedge clk);
    clear_state();
    for (int i = 0; i < 4; i++) dut.Mem[i] <= prog[i];
    dut.Mem[60] <= 32'h2222;
    put(0, 1, 9); put(0, 2, 2); put(1, 60, 32'h2222);
    release_reset();
    run_to_halt(100, cyc, nbr);
    total++; if (cyc !== 6) begin bad++; $display("FAIL fence_halt_cycle got %0d want 6", cyc); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      total++;
      if ({halted, pc} !== {1'b1, 10'd2}) begin
        bad++; $display("FAIL fence_hold cycle %0d got halted=%b pc=%0d want halted=1 pc=2", c, halted, pc);
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); act = peek(e); total++;
      if (act !== e.val) begin bad++; $display("FAIL fence_%s[%0d] got %h want %h", (e.kind == 0) ? "reg" : "mem", e.idx, act, e.val); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if ({halted, pc} !== {1'b0, 10'd0}) begin bad++; $display("FAIL fence_reset got halted=%b pc=%0d want halted=0 pc=0", halted, pc); end
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(100, cyc, nbr);
    total++; if (cyc !== 6) begin bad++; $display("FAIL fence_rerun_halt got %0d want 6", cyc); end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_back_to_back();
    test_loop();
    test_r0_unknown();
    test_reset_mid();
    test_halt_fence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
